// File: rtl/if_id_stage_if.sv
// -----------------------------------------------------------------------------
// if_id_pkg / if_id_stage_if
//
// Shared types and the bundled fetch/decode signals for if_id_stage.
//
// Package if_id_pkg:
//   word_t   - 32-bit datapath word
//   stage_t  - one fetched instruction record {instr, pc, pc4, valid}
//
// Interface if_id_stage_if (all signals owned by the interface):
//   Fetch side  : ihit, imemload, imemaddr, pc_plus_4
//   Control     : stall, freeze, flush
//   Stage output: pc_en, instr_id, pc_id, pc_plus_4_id, valid_id, skid_full
//
// Modports:
//   slave  - the if_id_stage itself (consumes fetch/control, drives outputs)
//   master - the surrounding pipeline (drives fetch/control, reads outputs)
// -----------------------------------------------------------------------------
package if_id_pkg;

  typedef logic [31:0] word_t;

  // One fetched instruction as it travels from fetch into decode.
  // The all-zero value is the bubble (MIPS sll $0,$0,0 with valid = 0).
  typedef struct packed {
    word_t instr;
    word_t pc;
    word_t pc4;
    logic  valid;
  } stage_t;

endpackage

interface if_id_stage_if;
  import if_id_pkg::*;

  // Fetch side
  logic  ihit;
  word_t imemload;
  word_t imemaddr;
  word_t pc_plus_4;

  // Pipeline control
  logic  stall;
  logic  freeze;
  logic  flush;

  // Stage outputs
  logic  pc_en;
  word_t instr_id;
  word_t pc_id;
  word_t pc_plus_4_id;
  logic  valid_id;
  logic  skid_full;

  modport slave (
    input  ihit, imemload, imemaddr, pc_plus_4,
    input  stall, freeze, flush,
    output pc_en, instr_id, pc_id, pc_plus_4_id, valid_id, skid_full
  );

  modport master (
    output ihit, imemload, imemaddr, pc_plus_4,
    output stall, freeze, flush,
    input  pc_en, instr_id, pc_id, pc_plus_4_id, valid_id, skid_full
  );

endinterface

// File: rtl/if_id_stage.sv
// -----------------------------------------------------------------------------
// if_id_stage
//
// Fetch/decode boundary register. Captures the word returned by instruction
// memory together with its fetch address and PC+4 and presents them to decode
// one cycle later. Also generates the combinational PC advance enable so the
// PC moves only when a fetched word has really been accepted somewhere.
//
// Ports:
//   CLK   - system clock, rising edge
//   RST   - asynchronous, active-high reset (clears decode register and skid,
//           forces pc_en low while asserted)
//   bus   - if_id_stage_if.slave: fetch inputs, stall/freeze/flush controls,
//           pc_en, decode outputs and skid_full
//
// Priority each cycle: freeze > flush > stall > advance.
//
// Build option:
//   IFID_SKID_EN - when defined, a one-entry skid buffer catches the word
//                  fetched during the first cycle of a stall so it does not
//                  have to be refetched. When undefined, a word returned
//                  during a stall is dropped, the PC holds, and skid_full = 0.
// -----------------------------------------------------------------------------
module if_id_stage
  import if_id_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  if_id_stage_if.slave  bus
);

  localparam stage_t BUBBLE = '0;

  // Decode register
  stage_t dec_q, dec_d;
  logic   pc_en_c;

  // The word on the fetch side this cycle, packaged as a valid record.
  stage_t fetch;
  always_comb begin
    fetch.instr = bus.imemload;
    fetch.pc    = bus.imemaddr;
    fetch.pc4   = bus.pc_plus_4;
    fetch.valid = 1'b1;
  end

`ifdef IFID_SKID_EN
  // -------------------------------------------------------------------------
  // Skid buffer compiled in
  // -------------------------------------------------------------------------
  stage_t skid_q, skid_d;
  logic   skid_full_q, skid_full_d;

  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the if/else chain can leave one unassigned and infer a latch.
    dec_d       = dec_q;
    skid_d      = skid_q;
    skid_full_d = skid_full_q;
    pc_en_c     = 1'b0;

    if (bus.freeze) begin
      // Whole pipeline holds, skid included; a pending flush waits for us.
    end else if (bus.flush) begin
      dec_d       = BUBBLE;
      skid_d      = BUBBLE;
      skid_full_d = 1'b0;
      pc_en_c     = 1'b1;
    end else if (bus.stall) begin
      // Decode holds. The first word fetched during the stall parks in the
      // skid so the PC can move on; later ones are ignored and refetched.
      if (bus.ihit && !skid_full_q) begin
        skid_d      = fetch;
        skid_full_d = 1'b1;
        pc_en_c     = 1'b1;
      end
    end else begin
      if (skid_full_q) begin
        // Oldest instruction is in the skid; drain it first and let any new
        // fetch take its place so program order is preserved.
        dec_d = skid_q;
        if (bus.ihit) begin
          skid_d  = fetch;
          pc_en_c = 1'b1;
        end else begin
          skid_d      = BUBBLE;
          skid_full_d = 1'b0;
        end
      end else if (bus.ihit) begin
        dec_d   = fetch;
        pc_en_c = 1'b1;
      end else begin
        dec_d = BUBBLE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dec_q       <= BUBBLE;
      skid_q      <= BUBBLE;
      skid_full_q <= 1'b0;
    end else begin
      dec_q       <= dec_d;
      skid_q      <= skid_d;
      skid_full_q <= skid_full_d;
    end
  end

  assign bus.skid_full = skid_full_q;

`else
  // -------------------------------------------------------------------------
  // Skid buffer compiled out
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the if/else chain can leave one unassigned and infer a latch.
    dec_d   = dec_q;
    pc_en_c = 1'b0;

    if (bus.freeze) begin
      // Whole pipeline holds; a pending flush waits for freeze to drop.
    end else if (bus.flush) begin
      dec_d   = BUBBLE;
      pc_en_c = 1'b1;
    end else if (bus.stall) begin
      // Decode holds; a word returned now is dropped and the PC stays put,
      // so the same address is fetched again after the stall.
    end else if (bus.ihit) begin
      dec_d   = fetch;
      pc_en_c = 1'b1;
    end else begin
      dec_d = BUBBLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dec_q <= BUBBLE;
    end else begin
      dec_q <= dec_d;
    end
  end

  assign bus.skid_full = 1'b0;

`endif

  // The PC stage must not advance while reset is held, even if ihit is high.
  assign bus.pc_en        = pc_en_c & ~RST;
  assign bus.instr_id     = dec_q.instr;
  assign bus.pc_id        = dec_q.pc;
  assign bus.pc_plus_4_id = dec_q.pc4;
  assign bus.valid_id     = dec_q.valid;

endmodule

// File: tb/tb_if_id_stage.sv
// -----------------------------------------------------------------------------
// tb_if_id_stage
//
// Table-driven bench for if_id_stage. Each row gives the inputs for one cycle
// and the outputs expected during that cycle (registered outputs reflect the
// preceding edges; pc_en reflects this row's inputs). Instruction words are
// 0xA000_0000 | address so each address carries a recognisable word.
// Hand-written sequences cover async reset mid-stream and, in the skid build,
// a flush while the skid is full during a stall.
// -----------------------------------------------------------------------------
module tb_if_id_stage;
  import if_id_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  if_id_stage_if bus ();

  if_id_stage dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic  ihit;
    word_t addr;
    logic  stall;
    logic  freeze;
    logic  flush;
    logic  e_pc_en;
    word_t e_instr;
    word_t e_pc;
    word_t e_pc4;
    logic  e_valid;
    logic  e_skid;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ihit, input word_t addr, input logic stall,
                       input logic freeze, input logic flush);
    bus.ihit      = ihit;
    bus.imemaddr  = addr;
    bus.imemload  = 32'hA000_0000 | addr;
    bus.pc_plus_4 = addr + 32'd4;
    bus.stall     = stall;
    bus.freeze    = freeze;
    bus.flush     = flush;
  endtask

  task automatic check_outs(input string tag, input logic pc_en, input word_t instr,
                            input word_t pc, input word_t pc4, input logic valid,
                            input logic skid);
    check({tag, ".pc_en"},        {31'd0, bus.pc_en},     {31'd0, pc_en});
    check({tag, ".instr_id"},     bus.instr_id,           instr);
    check({tag, ".pc_id"},        bus.pc_id,              pc);
    check({tag, ".pc_plus_4_id"}, bus.pc_plus_4_id,       pc4);
    check({tag, ".valid_id"},     {31'd0, bus.valid_id},  {31'd0, valid});
    check({tag, ".skid_full"},    {31'd0, bus.skid_full}, {31'd0, skid});
  endtask

  function automatic vec_t mk(logic ihit, word_t addr, logic stall, logic freeze,
                              logic flush, logic pe, word_t ins, word_t pc,
                              word_t pc4, logic v, logic sk);
    vec_t r;
    r.ihit = ihit; r.addr = addr; r.stall = stall; r.freeze = freeze; r.flush = flush;
    r.e_pc_en = pe; r.e_instr = ins; r.e_pc = pc; r.e_pc4 = pc4; r.e_valid = v;
    r.e_skid = sk;
    return r;
  endfunction

  initial begin
    //              ihit addr   st fz fl  pc_en instr          pc     pc4    v  skid
    // Reset then stream 0x0, 0x4, 0x8, 0xC
    vecs[0]  = mk(1, 32'h00, 0, 0, 0, 1, 32'h0,          32'h0,  32'h0,  0, 0);
    vecs[1]  = mk(1, 32'h04, 0, 0, 0, 1, 32'hA000_0000,  32'h0,  32'h4,  1, 0);
    vecs[2]  = mk(1, 32'h08, 0, 0, 0, 1, 32'hA000_0004,  32'h4,  32'h8,  1, 0);
    vecs[3]  = mk(1, 32'h0C, 0, 0, 0, 1, 32'hA000_0008,  32'h8,  32'hC,  1, 0);
`ifdef IFID_SKID_EN
    // Stall 3 cycles with ihit at 0x10: first word parks in skid, no refetch
    vecs[4]  = mk(1, 32'h10, 1, 0, 0, 1, 32'hA000_000C,  32'hC,  32'h10, 1, 0);
    vecs[5]  = mk(1, 32'h14, 1, 0, 0, 0, 32'hA000_000C,  32'hC,  32'h10, 1, 1);
    vecs[6]  = mk(1, 32'h14, 1, 0, 0, 0, 32'hA000_000C,  32'hC,  32'h10, 1, 1);
    vecs[7]  = mk(1, 32'h14, 0, 0, 0, 1, 32'hA000_000C,  32'hC,  32'h10, 1, 1);
    vecs[8]  = mk(1, 32'h18, 0, 0, 0, 1, 32'hA000_0010,  32'h10, 32'h14, 1, 1);
    // Freeze with flush: everything holds, then flush lands as a bubble
    vecs[9]  = mk(1, 32'h1C, 0, 1, 1, 0, 32'hA000_0014,  32'h14, 32'h18, 1, 1);
    vecs[10] = mk(1, 32'h1C, 0, 1, 1, 0, 32'hA000_0014,  32'h14, 32'h18, 1, 1);
    vecs[11] = mk(1, 32'h1C, 0, 0, 1, 1, 32'hA000_0014,  32'h14, 32'h18, 1, 1);
`else
    // Stall 3 cycles with ihit at 0x10: dropped, PC holds, refetch afterwards
    vecs[4]  = mk(1, 32'h10, 1, 0, 0, 0, 32'hA000_000C,  32'hC,  32'h10, 1, 0);
    vecs[5]  = mk(1, 32'h10, 1, 0, 0, 0, 32'hA000_000C,  32'hC,  32'h10, 1, 0);
    vecs[6]  = mk(1, 32'h10, 1, 0, 0, 0, 32'hA000_000C,  32'hC,  32'h10, 1, 0);
    vecs[7]  = mk(1, 32'h10, 0, 0, 0, 1, 32'hA000_000C,  32'hC,  32'h10, 1, 0);
    vecs[8]  = mk(1, 32'h14, 0, 0, 0, 1, 32'hA000_0010,  32'h10, 32'h14, 1, 0);
    // Freeze with flush: everything holds, then flush lands as a bubble
    vecs[9]  = mk(1, 32'h18, 0, 1, 1, 0, 32'hA000_0014,  32'h14, 32'h18, 1, 0);
    vecs[10] = mk(1, 32'h18, 0, 1, 1, 0, 32'hA000_0014,  32'h14, 32'h18, 1, 0);
    vecs[11] = mk(1, 32'h18, 0, 0, 1, 1, 32'hA000_0014,  32'h14, 32'h18, 1, 0);
`endif
    // Branch target stream, with an ihit gap giving a bubble
    vecs[12] = mk(1, 32'h40, 0, 0, 0, 1, 32'h0,          32'h0,  32'h0,  0, 0);
    vecs[13] = mk(0, 32'h44, 0, 0, 0, 0, 32'hA000_0040,  32'h40, 32'h44, 1, 0);
    vecs[14] = mk(1, 32'h44, 0, 0, 0, 1, 32'h0,          32'h0,  32'h0,  0, 0);
    // Flush together with stall still squashes and enables the PC
    vecs[15] = mk(1, 32'h48, 1, 0, 1, 1, 32'hA000_0044,  32'h44, 32'h48, 1, 0);
    vecs[16] = mk(0, 32'h80, 0, 0, 0, 0, 32'h0,          32'h0,  32'h0,  0, 0);

    // Reset state, with ihit high to show pc_en is held low in reset
    drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    check_outs("reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    @(posedge CLK); #1;
    RST = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].ihit, vecs[i].addr, vecs[i].stall, vecs[i].freeze, vecs[i].flush);
      #2;
      check_outs($sformatf("vec%0d", i), vecs[i].e_pc_en, vecs[i].e_instr,
                 vecs[i].e_pc, vecs[i].e_pc4, vecs[i].e_valid, vecs[i].e_skid);
      @(posedge CLK); #1;
    end

`ifdef IFID_SKID_EN
    // Flush during a stall while the skid holds a word
    drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
    @(posedge CLK); #1;
    drive(1'b1, 32'h104, 1'b1, 1'b0, 1'b1);
    #2;
    check_outs("skid_flush_cyc", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    @(posedge CLK); #1;
    drive(1'b0, 32'h200, 1'b0, 1'b0, 1'b0);
    #2;
    check_outs("skid_flush_after", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge CLK); #1;
`endif

    // Async reset between edges: outputs clear without a clock edge
    drive(1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
    @(posedge CLK); #1;
    drive(1'b1, 32'h304, 1'b1, 1'b0, 1'b0);
    @(posedge CLK); #1;
    check_outs("pre_rst", 1'b0 | dut_skid_pe(), 32'hA000_0300, 32'h300, 32'h304, 1'b1,
               skid_after_one_stall());
    #2;
    RST = 1'b1;
    #1;
    check_outs("async_rst", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge CLK); #1;
    RST = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Expected pc_en / skid_full in the second stalled cycle of the reset
  // sequence: the skid build has already parked 0x304 and so refuses further
  // fetches; the plain build never enables the PC during a stall.
  function automatic logic dut_skid_pe();
    return 1'b0;
  endfunction

  function automatic logic skid_after_one_stall();
`ifdef IFID_SKID_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

endmodule

// File: doc/if_id_stage.md
# if_id_stage

Fetch/decode boundary register that sits directly downstream of the PC stage. Captures the instruction returned by instruction memory together with its fetch address and PC+4, and presents them to decode one cycle later. Generates the PC advance enable, so the PC only moves when a fetched word has actually been accepted. Handles hazard stalls, memory freezes and branch/jump flushes, with an optional one-entry skid buffer that keeps instructions fetched during a stall from being refetched.

## Interface
Parameters: none. All data paths are 32 bits (`word_t`).

Ports:
- CLK  in  1  — system clock; all state updates on the rising edge.
- RST  in  1  — asynchronous, active-high reset.
- ihit  in  1  — instruction memory returned a valid word this cycle.
- imemload  in  32  — instruction word from instruction memory.
- imemaddr  in  32  — address of the word being fetched (PC stage output).
- pc_plus_4  in  32  — imemaddr + 4 (PC stage output).
- stall  in  1  — decode hazard stall; hold the decode register.
- freeze  in  1  — data-memory wait; the whole pipeline holds.
- flush  in  1  — taken branch/jump; squash the instruction currently being fetched.
- pc_en  out  1  — combinational PC advance enable.
- instr_id  out  32  — instruction presented to decode.
- pc_id  out  32  — fetch address of instr_id.
- pc_plus_4_id  out  32  — PC+4 of instr_id.
- valid_id  out  1  — instr_id is a real instruction; 0 means bubble.
- skid_full  out  1  — skid buffer occupied (always 0 when the skid is compiled out).

## Operation
Define `advance = ~stall & ~freeze`.

Priority, evaluated each cycle:
1. **freeze = 1**
   - All registers hold, including the skid buffer.
   - pc_en = 0.
   - flush is ignored; its source must hold flush until freeze drops.
2. **flush = 1**
   - Decode register loads a bubble: instr_id = 0x00000000, valid_id = 0, pc_id = 0, pc_plus_4_id = 0.
   - Skid buffer is cleared.
   - pc_en = 1, so the PC loads the branch/jump target.
   - This applies whether or not stall is asserted.
3. **stall = 1**
   - Decode register holds.
   - Skid behaviour is described under Configuration.
4. **advance**
   - If the skid is full: decode register loads the skid contents.
   - Otherwise, if ihit = 1: decode register loads {imemload, imemaddr, pc_plus_4} with valid_id = 1.
   - Otherwise: decode register loads a bubble.

Bubble encoding is all-zero, which is the MIPS `sll $0,$0,0` no-op.

## Timing
- **Reset:** all outputs and all state are 0 (bubble in decode, skid empty).
- **Latency:** data returned with ihit in cycle N appears on the decode outputs after the edge ending cycle N, i.e. is visible in cycle N+1.
- **pc_en:** purely combinational from ihit, stall, freeze, flush and skid state; no registered delay. The PC stage consumes it in the same cycle.
- **Decode outputs:** change only on a rising CLK edge or on assertion of RST.
- **Reset mid-operation:** decode outputs and skid clear immediately; pc_en = 0 while RST = 1.

## Configuration
Macro: `IFID_SKID_EN`.

Defined (skid buffer compiled in):
- pc_en = ~freeze & (flush | (ihit & (advance | ~skid_full))).
- stall & ihit & skid empty: capture {imemload, imemaddr, pc_plus_4} into the skid; skid_full ← 1; pc_en = 1.
- stall & skid full: skid holds; pc_en = 0 (the repeated ihit is ignored).
- advance & skid full & ihit: decode ← skid; skid ← new fetch; skid stays full; pc_en = 1.
- advance & skid full & ~ihit: decode ← skid; skid empties; pc_en = 0.

Not defined (skid buffer compiled out):
- pc_en = ~freeze & (flush | (ihit & ~stall)).
- An ihit during stall is dropped; the PC holds and the word is refetched after the stall.
- skid_full is tied to 0.

## Test plan
1. **Reset then stream:** release RST; ihit = 1 every cycle at addresses 0x0, 0x4, 0x8 → instr_id follows one cycle later; valid_id = 1; pc_plus_4_id = 0x4, 0x8, 0xC; pc_en = 1 throughout.
2. **Stall (skid compiled in):** stall for 3 cycles while ihit = 1 at 0x10 → skid_full = 1 after the first cycle; pc_en = 1 then 0, 0; after release, instr_id = word@0x10, then word@0x14, with no refetch of 0x10.
3. **Stall (skid compiled out):** same stimulus → pc_en = 0 for all 3 cycles; decode holds; after release, word@0x10 is loaded from a refetch.
4. **Flush during stall with skid full:** flush = 1 → next cycle valid_id = 0, instr_id = 0, skid_full = 0; pc_en = 1 in the flush cycle.
5. **Freeze with flush:** freeze = 1 and flush = 1 together → outputs unchanged, pc_en = 0; when freeze drops with flush still held, a bubble is loaded.
6. **Async reset mid-stream:** assert RST between clock edges → all outputs are 0 immediately, and skid_full = 0.
